branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor and EX-stage resolution checker. In IF it gives a same-cycle taken/target prediction for the fetch PC from a direct-mapped BTB with 2-bit saturating counters. In EX it takes the resolved outcome from the branch unit's `take_branch`, flags mispredictions with the redirect PC, trains the tables, and keeps performance counters.

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_sat_counter.sv | 20 ++
 rtl/branch_predictor.sv | 109 ++++++++++
 tb/tb_branch_predictor.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_pkg;

   // Default geometry. The entry struct is sized from these, so a different
   // table shape is selected here rather than by per-instance overrides.
   localparam int BP_XLEN    = 32;
   localparam int BP_ENTRIES = 16;
   localparam int BP_IDX_W   = $clog2(BP_ENTRIES);
   localparam int BP_TAG_W   = BP_XLEN - BP_IDX_W - 2;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_e;

   typedef struct packed {
      logic                valid;
      logic [BP_TAG_W-1:0] tag;
      logic [BP_XLEN-1:0]  target;
      bp_ctr_e             ctr;
   } btb_entry_t;

   // Invalid entries rest weakly not-taken; fresh allocations start weakly taken
   // so one contrary outcome is enough to flip them.
   localparam bp_ctr_e BP_CTR_RESET = WNT;
   localparam bp_ctr_e BP_CTR_ALLOC = WT;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic.
// Latency: combinational.
// Backpressure: none.
module bp_sat_counter (
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_nxt
);

   // Step toward the observed outcome, sticking at 00 and 11.
   always_comb begin
      ctr_nxt = ctr;
      if (taken && ctr != 2'b11) begin
         ctr_nxt = ctr + 2'd1;
      end else if (!taken && ctr != 2'b00) begin
         ctr_nxt = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit BHT: IF prediction, EX misprediction check, training, perf counters.
// Latency: prediction and mispredict/redirect are combinational; table/counter writes land on the next edge.
// Backpressure: none; one EX resolution may be accepted every cycle.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = BP_XLEN,
   parameter int ENTRIES = BP_ENTRIES
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_branch,
   input  logic [XLEN-1:0] ex_pc,
   input  logic            ex_taken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     branch_count,
   output logic [31:0]     mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   // Flop array rather than SRAM so reset invalidates every entry at once.
   btb_entry_t table_q [ENTRIES];

   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;
   logic             br;
   logic             ex_alias;
   logic [1:0]       ctr_nxt;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[XLEN-1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

   assign br       = ex_valid && ex_branch;
   // A non-branch that was predicted taken means a BTB entry aliased onto it.
   assign ex_alias = ex_valid && !ex_branch && ex_pred_taken;
   assign ex_hit   = table_q[ex_idx].valid && (table_q[ex_idx].tag == ex_tag);

   // Fetch lookup reads the table before any same-cycle training write.
   always_comb begin
      if_hit      = table_q[if_idx].valid && (table_q[if_idx].tag == if_tag);
      pred_taken  = if_hit && (table_q[if_idx].ctr == WT || table_q[if_idx].ctr == ST);
      pred_target = pred_taken ? table_q[if_idx].target : if_pc + XLEN'(4);
   end

   // Resolution check: wrong direction, wrong taken target, or an aliased non-branch.
   always_comb begin
      mispredict  = (br && ((ex_taken != ex_pred_taken) ||
                            (ex_taken && ex_target != ex_pred_target))) || ex_alias;
      redirect_pc = (br && ex_taken) ? ex_target : ex_pc + XLEN'(4);
   end

   bp_sat_counter u_sat_counter (
      .ctr     (table_q[ex_idx].ctr),
      .taken   (ex_taken),
      .ctr_nxt (ctr_nxt)
   );

   // Train on resolved branches; allocate only on a taken miss; drop aliased entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BP_CTR_RESET};
         end
      end else if (br) begin
         if (ex_hit) begin
            table_q[ex_idx].ctr <= bp_ctr_e'(ctr_nxt);
            if (ex_taken) begin
               table_q[ex_idx].target <= ex_target;
            end
         end else if (ex_taken) begin
            table_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: ex_target, ctr: BP_CTR_ALLOC};
         end
      end else if (ex_alias && ex_hit) begin
         table_q[ex_idx].valid <= 1'b0;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         if (br && branch_count != 32'hFFFF_FFFF) begin
            branch_count <= branch_count + 32'd1;
         end
         if (mispredict && mispredict_count != 32'hFFFF_FFFF) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// checked against an array-based reference model.
// Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_branch_predictor;

   localparam longint CNT_MAX = 64'hFFFF_FFFF;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic        ex_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   branch_predictor dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_branch        (ex_branch),
      .ex_pc            (ex_pc),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;

   // Reference model: one slot per index, counter as an integer 0..3.
   bit          m_valid [16];
   int unsigned m_tag   [16];
   logic [31:0] m_tgt   [16];
   int          m_ctr   [16];
   longint      m_bc;
   longint      m_mc;

   // Values observed during the last cycle() call, for directed checks.
   logic        obs_pt;
   logic [31:0] obs_ptgt;
   logic        obs_mp;
   logic [31:0] obs_rd;
   logic [31:0] obs_bc;
   logic [31:0] obs_mc;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_bc = 0;
      m_mc = 0;
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int idx;
      idx = int'((pc >> 2) % 16);
      return m_valid[idx] && (m_tag[idx] == int'(pc >> 6));
   endfunction

   function automatic void model_lookup(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
      int idx;
      idx = int'((pc >> 2) % 16);
      pt  = model_hit(pc) && (m_ctr[idx] >= 2);
      tgt = pt ? m_tgt[idx] : pc + 32'd4;
   endfunction

   function automatic bit model_mp(input logic v, b, tk, input logic [31:0] tgt,
                                   input logic ptk, input logic [31:0] ptgt);
      if (v && b)
         return (tk != ptk) || (tk && tgt != ptgt);
      return v && ptk;
   endfunction

   function automatic void model_update(input logic v, b, input logic [31:0] pc, input logic tk,
                                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      int idx;
      bit hit;
      idx = int'((pc >> 2) % 16);
      hit = model_hit(pc);
      if (model_mp(v, b, tk, tgt, ptk, ptgt) && m_mc < CNT_MAX) m_mc++;
      if (v && b) begin
         if (m_bc < CNT_MAX) m_bc++;
         if (hit) begin
            m_ctr[idx] = tk ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                            : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
            if (tk) m_tgt[idx] = tgt;
         end else if (tk) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = int'(pc >> 6);
            m_tgt[idx]   = tgt;
            m_ctr[idx]   = 2;
         end
      end else if (v && ptk && hit) begin
         m_valid[idx] = 1'b0;
      end
   endfunction

   // One clock: drive, check every output at the falling edge, advance the model at the rising edge.
   task automatic cycle(input logic [31:0] ipc, input logic v, input logic b, input logic [31:0] epc,
                        input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mp;
      logic [31:0] e_rd;
      if_pc = ipc; ex_valid = v; ex_branch = b; ex_pc = epc;
      ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
      #4;
      model_lookup(ipc, e_pt, e_ptgt);
      e_mp = model_mp(v, b, tk, tgt, ptk, ptgt);
      e_rd = (v && b && tk) ? tgt : epc + 32'd4;
      obs_pt = pred_taken; obs_ptgt = pred_target; obs_mp = mispredict;
      obs_rd = redirect_pc; obs_bc = branch_count; obs_mc = mispredict_count;
      check_val("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
      check_val("pred_target", pred_target, e_ptgt);
      check_val("mispredict", {31'd0, mispredict}, {31'd0, e_mp});
      check_val("redirect_pc", redirect_pc, e_rd);
      check_val("branch_count", branch_count, m_bc[31:0]);
      check_val("mispredict_count", mispredict_count, m_mc[31:0]);
      @(posedge clk);
      if (rst_n) model_update(v, b, epc, tk, tgt, ptk, ptgt);
      #1;
   endtask

   task automatic idle(input logic [31:0] ipc);
      cycle(ipc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [31:0] mc_before;

   initial begin
      rst_n = 1'b0;
      if_pc = '0; ex_valid = 1'b0; ex_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0;
      ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
      do_reset();

      // Reset state.
      idle(32'h100);
      check_val("rst_pt", {31'd0, obs_pt}, 32'd0);
      check_val("rst_ptgt", obs_ptgt, 32'h104);
      check_val("rst_bc", obs_bc, 32'd0);
      check_val("rst_mc", obs_mc, 32'd0);

      // Taken miss allocates and mispredicts.
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
      check_val("alloc_mp", {31'd0, obs_mp}, 32'd1);
      check_val("alloc_rd", obs_rd, 32'h200);
      idle(32'h100);
      check_val("alloc_pt", {31'd0, obs_pt}, 32'd1);
      check_val("alloc_ptgt", obs_ptgt, 32'h200);

      // Not taken twice: WT -> WNT -> SNT.
      cycle(32'h0, 1, 1, 32'h100, 0, 32'h200, 1, 32'h200);
      mc_before = obs_mc;
      check_val("nt1_mp", {31'd0, obs_mp}, 32'd1);
      check_val("nt1_rd", obs_rd, 32'h104);
      cycle(32'h0, 1, 1, 32'h100, 0, 32'h200, 0, 32'h104);
      check_val("nt2_mp", {31'd0, obs_mp}, 32'd0);
      idle(32'h100);
      check_val("nt_mc_delta", obs_mc, mc_before + 32'd1);

      // Drive back to ST, then check aliasing.
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
      idle(32'h140);
      check_val("alias_other_tag", {31'd0, obs_pt}, 32'd0);
      cycle(32'h100, 1, 0, 32'h100, 0, 32'h0, 1, 32'h200);
      check_val("alias_mp", {31'd0, obs_mp}, 32'd1);
      check_val("alias_rd", obs_rd, 32'h104);
      check_val("alias_same_cycle_pt", {31'd0, obs_pt}, 32'd1);
      idle(32'h100);
      check_val("alias_inval", {31'd0, obs_pt}, 32'd0);

      // Target change on a strongly-taken hit.
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
      cycle(32'h0, 1, 1, 32'h100, 1, 32'h300, 1, 32'h200);
      check_val("tchg_mp", {31'd0, obs_mp}, 32'd1);
      check_val("tchg_rd", obs_rd, 32'h300);
      idle(32'h100);
      check_val("tchg_ptgt", obs_ptgt, 32'h300);

      // Counter saturation.
      force dut.branch_count = 32'hFFFF_FFFF;
      force dut.mispredict_count = 32'hFFFF_FFFF;
      #1;
      release dut.branch_count;
      release dut.mispredict_count;
      m_bc = CNT_MAX;
      m_mc = CNT_MAX;
      cycle(32'h0, 1, 1, 32'h180, 1, 32'h400, 0, 32'h184);
      idle(32'h0);
      check_val("sat_bc", obs_bc, 32'hFFFF_FFFF);
      check_val("sat_mc", obs_mc, 32'hFFFF_FFFF);

      // Reset asserted mid-cycle while a taken miss is being presented.
      if_pc = 32'h1C0; ex_valid = 1; ex_branch = 1; ex_pc = 32'h1C0; ex_taken = 1;
      ex_target = 32'h500; ex_pred_taken = 0; ex_pred_target = 32'h1C4;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("mid_rst_bc", branch_count, 32'd0);
      check_val("mid_rst_mc", mispredict_count, 32'd0);
      check_val("mid_rst_pt_180", {31'd0, pred_taken}, 32'd0);
      check_val("mid_rst_mp", {31'd0, mispredict}, 32'd1);
      @(posedge clk);
      #1;
      cycle(32'h100, 1, 1, 32'h1C0, 1, 32'h500, 0, 32'h1C4);
      check_val("rst_hold_pt", {31'd0, obs_pt}, 32'd0);
      rst_n = 1'b1;
      idle(32'h1C0);
      check_val("rst_no_alloc", {31'd0, obs_pt}, 32'd0);

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ipc, epc, tgt, ptgt;
         logic v, b, tk, ptk;
         ipc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         epc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         tgt = 32'h1000 + ($urandom_range(0, 3) << 4);
         v   = ($urandom_range(0, 9) != 0);
         b   = ($urandom_range(0, 3) != 0);
         tk  = $urandom_range(0, 1) != 0;
         if ($urandom_range(0, 4) != 0) begin
            model_lookup(epc, ptk, ptgt);
         end else begin
            ptk  = $urandom_range(0, 1) != 0;
            ptgt = 32'h1000 + ($urandom_range(0, 3) << 4);
         end
         if (n == 200) ipc = 32'hFFFF_FFFC;
         cycle(ipc, v, b, epc, tk, tgt, ptk, ptgt);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
